// File: rtl/pc_update_unit.sv
// rtl/pc_update_unit.sv - next-PC generator with alignment check and fetch/execute handshakes
module pc_update_unit #(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(64'h8000_0000),
    parameter int              IALIGN    = 4,
    parameter int              CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             upd_valid,
    output logic             upd_ready,
    input  logic [2:0]       upd_mode,
    input  logic             upd_taken,
    input  logic [XLEN-1:0]  upd_imm,
    input  logic [XLEN-1:0]  upd_rs1,
    input  logic [XLEN-1:0]  trap_vec,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_addr,
    output logic [XLEN-1:0]  pc_out,
    output logic             pc_valid,
    output logic [XLEN-1:0]  link_addr,
    output logic             misalign_exc,
    output logic [XLEN-1:0]  misalign_addr,
    output logic [CNT_W-1:0] upd_count
);

    localparam logic [2:0] MODE_SEQ  = 3'd0;
    localparam logic [2:0] MODE_BR   = 3'd1;
    localparam logic [2:0] MODE_JAL  = 3'd2;
    localparam logic [2:0] MODE_JALR = 3'd3;
    localparam logic [2:0] MODE_TRAP = 3'd4;

    // Low address bits that must be zero for a legal instruction address.
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);

    typedef enum logic [1:0] {
        ST_BOOT      = 2'd0,
        ST_RUN       = 2'd1,
        ST_TRAP_WAIT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [XLEN-1:0]  r_pc;
    logic             r_misalign_exc;
    logic [XLEN-1:0]  r_misalign_addr;
    logic [CNT_W-1:0] r_upd_count;

    logic [XLEN-1:0]  w_pc_plus4;
    logic [XLEN-1:0]  w_pc_plus_imm;
    logic [XLEN-1:0]  w_jalr_tgt;
    logic [XLEN-1:0]  w_raw_tgt;
    logic [XLEN-1:0]  w_target;
    logic             w_is_trap;
    logic             w_misalign;
    logic             w_redirect;
    logic             w_upd_ready;
    logic             w_pc_valid;
    logic             w_accept;
    logic [XLEN-1:0]  w_redirect_tgt;

    assign w_pc_plus4     = r_pc + XLEN'(4);
    assign w_pc_plus_imm  = r_pc + upd_imm;
    assign w_jalr_tgt     = (upd_rs1 + upd_imm) & ~XLEN'(1);
    assign w_redirect_tgt = redirect_addr & ~ALIGN_MASK;

    // Redirects are ignored while booting; elsewhere they pre-empt any update.
    assign w_redirect = redirect_valid && (r_state != ST_BOOT);
    assign w_accept   = upd_valid && w_upd_ready;

    // Raw successor PC for the requested control decision; reserved modes fall back to sequential.
    always_comb begin
        w_raw_tgt = w_pc_plus4;
        w_is_trap = 1'b0;
        case (upd_mode)
            MODE_SEQ:  w_raw_tgt = w_pc_plus4;
            MODE_BR:   w_raw_tgt = upd_taken ? w_pc_plus_imm : w_pc_plus4;
            MODE_JAL:  w_raw_tgt = w_pc_plus_imm;
            MODE_JALR: w_raw_tgt = w_jalr_tgt;
            MODE_TRAP: begin
                w_raw_tgt = trap_vec;
                w_is_trap = 1'b1;
            end
            default:   w_raw_tgt = w_pc_plus4;
        endcase
    end

    // Trap vectors are force-aligned; every other target is checked instead.
    assign w_target   = w_is_trap ? (w_raw_tgt & ~ALIGN_MASK) : w_raw_tgt;
    assign w_misalign = !w_is_trap && ((w_raw_tgt & ALIGN_MASK) != '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next_state = r_state;
        w_pc_valid   = 1'b0;
        w_upd_ready  = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_next_state = ST_RUN;
            end
            ST_RUN: begin
                w_pc_valid  = 1'b1;
                w_upd_ready = !w_redirect;
                if (!w_redirect && upd_valid && w_misalign) begin
                    w_next_state = ST_TRAP_WAIT;
                end
            end
            ST_TRAP_WAIT: begin
                if (w_redirect) begin
                    w_next_state = ST_RUN;
                end
            end
            default: begin
                w_next_state = ST_BOOT;
            end
        endcase
    end

    // PC, exception reporting and accepted-update counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc            <= RESET_VEC;
            r_misalign_exc  <= 1'b0;
            r_misalign_addr <= '0;
            r_upd_count     <= '0;
        end else begin
            r_misalign_exc <= 1'b0;
            if (w_redirect) begin
                r_pc <= w_redirect_tgt;
            end else if (w_accept) begin
                r_upd_count <= r_upd_count + CNT_W'(1);
                if (w_misalign) begin
                    r_misalign_exc  <= 1'b1;
                    r_misalign_addr <= w_raw_tgt;
                end else begin
                    r_pc <= w_target;
                end
            end
        end
    end

    assign upd_ready     = w_upd_ready;
    assign pc_valid      = w_pc_valid;
    assign pc_out        = r_pc;
    assign link_addr     = w_pc_plus4;
    assign misalign_exc  = r_misalign_exc;
    assign misalign_addr = r_misalign_addr;
    assign upd_count     = r_upd_count;

endmodule

// File: tb/tb_pc_update_unit.sv
// tb/tb_pc_update_unit.sv - directed self-checking bench for pc_update_unit
module tb_pc_update_unit;

    logic        clk;
    logic        rst;
    logic        upd_valid;
    logic [2:0]  upd_mode;
    logic        upd_taken;
    logic [63:0] upd_imm;
    logic [63:0] upd_rs1;
    logic [63:0] trap_vec;
    logic        redirect_valid;
    logic [63:0] redirect_addr;

    logic        upd_ready;
    logic [63:0] pc_out;
    logic        pc_valid;
    logic [63:0] link_addr;
    logic        misalign_exc;
    logic [63:0] misalign_addr;
    logic [3:0]  upd_count;

    logic        b_upd_ready;
    logic [63:0] b_pc_out;
    logic        b_pc_valid;
    logic [63:0] b_link_addr;
    logic        b_misalign_exc;
    logic [63:0] b_misalign_addr;
    logic [3:0]  b_upd_count;

    int n_checks = 0;
    int n_fail   = 0;

    pc_update_unit #(.XLEN(64), .RESET_VEC(64'h8000_0000), .IALIGN(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_mode(upd_mode),
        .upd_taken(upd_taken), .upd_imm(upd_imm), .upd_rs1(upd_rs1),
        .trap_vec(trap_vec), .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .pc_out(pc_out), .pc_valid(pc_valid), .link_addr(link_addr),
        .misalign_exc(misalign_exc), .misalign_addr(misalign_addr), .upd_count(upd_count)
    );

    pc_update_unit #(.XLEN(64), .RESET_VEC(64'h8000_0000), .IALIGN(2), .CNT_W(4)) dut_a2 (
        .clk(clk), .rst(rst),
        .upd_valid(upd_valid), .upd_ready(b_upd_ready), .upd_mode(upd_mode),
        .upd_taken(upd_taken), .upd_imm(upd_imm), .upd_rs1(upd_rs1),
        .trap_vec(trap_vec), .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .pc_out(b_pc_out), .pc_valid(b_pc_valid), .link_addr(b_link_addr),
        .misalign_exc(b_misalign_exc), .misalign_addr(b_misalign_addr), .upd_count(b_upd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic v, input logic [2:0] m, input logic t,
                           input logic [63:0] imm, input logic [63:0] rs1);
        upd_valid = v;
        upd_mode  = m;
        upd_taken = t;
        upd_imm   = imm;
        upd_rs1   = rs1;
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        trap_vec       = '0;
        set_upd(1'b0, 3'd0, 1'b0, '0, '0);

        // Reset state
        tick();
        tick();
        check_eq("rst_pc",        pc_out, 64'h8000_0000);
        check_eq("rst_pc_valid",  {63'd0, pc_valid}, 64'd0);
        check_eq("rst_ready",     {63'd0, upd_ready}, 64'd0);
        check_eq("rst_exc",       {63'd0, misalign_exc}, 64'd0);
        check_eq("rst_maddr",     misalign_addr, 64'd0);
        check_eq("rst_count",     {60'd0, upd_count}, 64'd0);

        // BOOT lasts one cycle after rst drops
        rst = 1'b0;
        check_eq("boot_pc_valid", {63'd0, pc_valid}, 64'd0);
        tick();
        check_eq("run_pc_valid",  {63'd0, pc_valid}, 64'd1);
        check_eq("run_ready",     {63'd0, upd_ready}, 64'd1);
        check_eq("link_addr",     link_addr, 64'h8000_0004);

        // Sequential, branch taken (-8), branch not taken
        set_upd(1'b1, 3'd0, 1'b0, '0, '0);
        tick();
        check_eq("seq_pc",        pc_out, 64'h8000_0004);
        set_upd(1'b1, 3'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, '0);
        tick();
        check_eq("br_t_pc",       pc_out, 64'h7FFF_FFFC);
        check_eq("br_t_count",    {60'd0, upd_count}, 64'd2);
        set_upd(1'b1, 3'd1, 1'b0, 64'h0000_0000_0000_0100, '0);
        tick();
        check_eq("br_nt_pc",      pc_out, 64'h8000_0000);

        // JAL, reserved mode, trap with force-alignment
        set_upd(1'b1, 3'd2, 1'b0, 64'h100, '0);
        tick();
        check_eq("jal_pc",        pc_out, 64'h8000_0100);
        set_upd(1'b1, 3'd6, 1'b1, 64'h40, '0);
        tick();
        check_eq("rsvd_pc",       pc_out, 64'h8000_0104);
        trap_vec = 64'h8000_0203;
        set_upd(1'b1, 3'd4, 1'b0, '0, '0);
        tick();
        check_eq("trap_pc",       pc_out, 64'h8000_0200);
        check_eq("trap_no_exc",   {63'd0, misalign_exc}, 64'd0);
        check_eq("trap_pc_a2",    b_pc_out, 64'h8000_0202);
        check_eq("trap_count",    {60'd0, upd_count}, 64'd6);

        // JALR to 0x8000_1002: misaligned for IALIGN=4, legal for IALIGN=2
        set_upd(1'b1, 3'd3, 1'b0, '0, 64'h8000_1003);
        tick();
        check_eq("jalr_exc",      {63'd0, misalign_exc}, 64'd1);
        check_eq("jalr_maddr",    misalign_addr, 64'h8000_1002);
        check_eq("jalr_pc_hold",  pc_out, 64'h8000_0200);
        check_eq("jalr_ready",    {63'd0, upd_ready}, 64'd0);
        check_eq("jalr_pc_valid", {63'd0, pc_valid}, 64'd0);
        check_eq("jalr_count",    {60'd0, upd_count}, 64'd7);
        check_eq("jalr_a2_pc",    b_pc_out, 64'h8000_1002);
        check_eq("jalr_a2_exc",   {63'd0, b_misalign_exc}, 64'd0);

        // Held request in TRAP_WAIT has no effect; pulse is one cycle
        set_upd(1'b1, 3'd0, 1'b0, '0, '0);
        tick();
        check_eq("tw_exc_pulse",  {63'd0, misalign_exc}, 64'd0);
        check_eq("tw_pc",         pc_out, 64'h8000_0200);
        check_eq("tw_count",      {60'd0, upd_count}, 64'd7);
        check_eq("tw_maddr_hold", misalign_addr, 64'h8000_1002);

        // Redirect out of TRAP_WAIT, low bits cleared
        set_upd(1'b0, 3'd0, 1'b0, '0, '0);
        redirect_valid = 1'b1;
        redirect_addr  = 64'h8000_0101;
        tick();
        redirect_valid = 1'b0;
        check_eq("redir_pc",      pc_out, 64'h8000_0100);
        check_eq("redir_run",     {63'd0, pc_valid}, 64'd1);
        check_eq("redir_a2_pc",   b_pc_out, 64'h8000_0100);

        // Redirect beats a simultaneous JAL
        redirect_valid = 1'b1;
        redirect_addr  = 64'h8000_0400;
        set_upd(1'b1, 3'd2, 1'b0, 64'h10, '0);
        #1;
        check_eq("redir_ready",   {63'd0, upd_ready}, 64'd0);
        tick();
        check_eq("redir_jal_pc",  pc_out, 64'h8000_0400);
        check_eq("redir_jal_cnt", {60'd0, upd_count}, 64'd7);

        // PC wrap-around
        set_upd(1'b0, 3'd0, 1'b0, '0, '0);
        redirect_addr = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        set_upd(1'b1, 3'd0, 1'b0, '0, '0);
        tick();
        check_eq("wrap_pc",       pc_out, 64'd0);
        check_eq("wrap_exc",      {63'd0, misalign_exc}, 64'd0);
        check_eq("wrap_count",    {60'd0, upd_count}, 64'd8);

        // Counter wraps 15 -> 0 (4-bit instance)
        for (int i = 0; i < 8; i++) tick();
        check_eq("cnt_wrap",      {60'd0, upd_count}, 64'd0);
        check_eq("cnt_wrap_pc",   pc_out, 64'h20);

        // Enter TRAP_WAIT via JAL +2, then reset mid-trap
        set_upd(1'b1, 3'd2, 1'b0, 64'h2, '0);
        tick();
        set_upd(1'b0, 3'd0, 1'b0, '0, '0);
        check_eq("jal_mis_maddr", misalign_addr, 64'h22);
        rst = 1'b1;
        tick();
        check_eq("rst2_pc",       pc_out, 64'h8000_0000);
        check_eq("rst2_maddr",    misalign_addr, 64'd0);
        check_eq("rst2_count",    {60'd0, upd_count}, 64'd0);
        rst = 1'b0;
        check_eq("rst2_boot",     {63'd0, pc_valid}, 64'd0);
        tick();
        check_eq("rst2_run",      {63'd0, pc_valid}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_update_unit.md
Name: pc_update_unit

Overview:
- Parametrised next-PC generator for the npc core.
- Owns the architectural PC register and computes the successor on each retired control decision: sequential, conditional branch, JAL, JALR or trap target.
- Enforces instruction-address alignment and raises a misalignment exception when a target violates it.
- Presents the PC to fetch through a valid flag and accepts updates from execute through a valid/ready handshake.

Parameters:
- XLEN, 64, width of PC, immediates and register operands.
- RESET_VEC, 64'h8000_0000, PC value loaded on reset.
- IALIGN, 4, instruction alignment in bytes; legal values are 2 or 4.
- CNT_W, 32, width of the accepted-update counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- upd_valid  in  1  execute presents a PC update.
- upd_ready  out  1  unit can accept an update this cycle.
- upd_mode  in  3  0 SEQ, 1 BR, 2 JAL, 3 JALR, 4 TRAP; 5-7 reserved.
- upd_taken  in  1  branch outcome; used only in BR mode.
- upd_imm  in  XLEN  sign-extended byte offset; already scaled, no internal shift.
- upd_rs1  in  XLEN  JALR base register value.
- trap_vec  in  XLEN  target used in TRAP mode.
- redirect_valid  in  1  external redirect (flush, mret, debug).
- redirect_addr  in  XLEN  redirect target.
- pc_out  out  XLEN  current PC.
- pc_valid  out  1  pc_out is fetchable.
- link_addr  out  XLEN  pc_out + 4, combinational.
- misalign_exc  out  1  one-cycle exception pulse.
- misalign_addr  out  XLEN  offending target; held until the next exception or reset.
- upd_count  out  CNT_W  number of accepted updates.

Behaviour:
- Reset (rst=1 at a clock edge):
  - pc_out=RESET_VEC, state=BOOT.
  - pc_valid=0, upd_ready=0, misalign_exc=0, misalign_addr=0, upd_count=0.
  - rst overrides every other input, including when asserted mid-operation.
- FSM states: BOOT, RUN, TRAP_WAIT.
  - BOOT: lasts exactly one cycle after rst deasserts, then goes to RUN. pc_valid=0, upd_ready=0.
  - RUN: pc_valid=1, upd_ready=1.
  - TRAP_WAIT: pc_valid=0, upd_ready=0. Leaves only on redirect_valid.
- Accept: an update is accepted when upd_valid && upd_ready at a clock edge. The new PC is visible on pc_out the next cycle (latency 1).
- Target computation, all modulo 2^XLEN with silent wrap:
  - SEQ: pc+4.
  - BR: pc+upd_imm if upd_taken, else pc+4.
  - JAL: pc+upd_imm.
  - JALR: (upd_rs1+upd_imm) with bit 0 cleared.
  - TRAP: trap_vec.
- Alignment check: if target mod IALIGN != 0 and mode is not TRAP:
  - pc_out is unchanged.
  - misalign_exc=1 for exactly one cycle.
  - misalign_addr=target.
  - state goes to TRAP_WAIT.
  - upd_count still increments.
- TRAP-mode targets are force-aligned (low log2(IALIGN) bits cleared) and never raise misalign_exc.
- Reserved mode: treated as SEQ.
- upd_count increments by 1 per accepted update and wraps from all-ones to 0.
- Redirect:
  - If redirect_valid is high in RUN or TRAP_WAIT: pc_out <= redirect_addr with low log2(IALIGN) bits cleared, then state goes to RUN next cycle.
  - Redirect has priority over a simultaneous update; that update is not accepted and not counted.
  - In BOOT, redirect_valid is ignored.
- Simultaneous misalign_exc and redirect cannot occur, because redirect blocks acceptance.
- upd_valid while upd_ready=0 has no effect. Execute must hold the request.

Test Plan:
- Reset then idle: pc_out=0x8000_0000, pc_valid=0 for one cycle, then 1; upd_ready rises with pc_valid.
- SEQ update at 0x8000_0000, then BR taken with imm=-8: pc_out goes 0x8000_0004, then 0x7FFF_FFFC; upd_count=2; BR not-taken gives +4.
- JALR with rs1=0x8000_1003, imm=0, IALIGN=4: target 0x8000_1002 is misaligned, so misalign_exc pulses 1 cycle, misalign_addr=0x8000_1002, pc_out holds, upd_ready=0. Then redirect to 0x8000_0101 gives pc_out=0x8000_0100 in RUN.
- Same JALR with IALIGN=2: pc_out=0x8000_1002, no exception.
- Redirect and valid JAL in the same cycle: pc_out=redirect target, upd_count unchanged.
- Wrap-around: pc=0xFFFF_FFFF_FFFF_FFFC with SEQ gives pc_out=0, no exception. upd_count at all-ones plus one accept gives 0.
- rst asserted while in TRAP_WAIT: next cycle state is BOOT, pc_out=RESET_VEC, misalign_addr=0.
